// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined run-time selectable bitwise logic unit with valid/ready backpressure.
// Optional build macro LOGIC_UNIT_POPCNT_EN adds a pipelined popcount of each result on out_popcnt.
module logic_unit_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_op,
    output logic [CNT_WIDTH-1:0] beat_cnt
`ifdef LOGIC_UNIT_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);
    logic                 adv;
    logic [WIDTH-1:0]     res_d;
    logic                 valid_q [PIPE_STAGES];
    logic [WIDTH-1:0]     data_q  [PIPE_STAGES];
    logic [2:0]           op_q    [PIPE_STAGES];
    logic [CNT_WIDTH-1:0] beat_cnt_q;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;
    assign out_valid = valid_q[PIPE_STAGES-1];
    assign out_data  = data_q[PIPE_STAGES-1];
    assign out_op    = op_q[PIPE_STAGES-1];
    assign beat_cnt  = beat_cnt_q;

    // stage 0 operator decode
    always_comb begin
        res_d = in_a;
        case (in_op)
            3'd0: res_d = in_a & in_b;
            3'd1: res_d = in_a | in_b;
            3'd2: res_d = in_a ^ in_b;
            3'd3: res_d = ~(in_a & in_b);
            3'd4: res_d = ~(in_a | in_b);
            3'd5: res_d = ~(in_a ^ in_b);
            3'd6: res_d = in_a & ~in_b;
            default: res_d = in_a;
        endcase
    end

    // whole pipeline advances together; a stall freezes every stage including bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                op_q[i]    <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= res_d;
            op_q[0]    <= in_op;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                op_q[i]    <= op_q[i-1];
            end
        end
    end

    // saturating count of delivered result beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt_q <= '0;
        else if (out_valid && out_ready && beat_cnt_q != {CNT_WIDTH{1'b1}})
            beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
    end

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int PW = $clog2(WIDTH+1);
    logic [PW-1:0] pop_d;
    logic [PW-1:0] pop_q [PIPE_STAGES];

    assign out_popcnt = pop_q[PIPE_STAGES-1];

    // popcount of the stage 0 result
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < WIDTH; i++)
            pop_d = pop_d + PW'(res_d[i]);
    end

    // popcount rides alongside the data so out_popcnt stays registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++)
                pop_q[i] <= '0;
        end else if (adv) begin
            pop_q[0] <= pop_d;
            for (int i = 1; i < PIPE_STAGES; i++)
                pop_q[i] <= pop_q[i-1];
        end
    end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed scoreboard bench for logic_unit_pipe (WIDTH=8, PIPE_STAGES=2, CNT_WIDTH=4).
module tb_logic_unit_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [2:0] out_op;
    logic [3:0] beat_cnt;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [3:0] out_popcnt;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] op;
        logic [3:0] pc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_cnt = '0;
    int         checks = 0;
    int         failures = 0;

    logic_unit_pipe #(.WIDTH(8), .PIPE_STAGES(2), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_op(out_op), .beat_cnt(beat_cnt)
`ifdef LOGIC_UNIT_POPCNT_EN
        , .out_popcnt(out_popcnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return a & ~b;
            default: return a;
        endcase
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [7:0] exp_d);
        exp_t e;
        bit   done = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = exp_d;
                e.op = op;
                e.pc = 4'($countones(exp_d));
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL send_timeout got=in_ready_low exp=accept");
        end
    endtask

    task automatic send_rand();
        logic [7:0] a, b;
        logic [2:0] op;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 3'($urandom_range(0, 7));
        send(a, b, op, model(a, b, op));
    endtask

    task automatic drain();
        int k = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL drain_timeout got=%0d pending exp=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // output monitor: pops the scoreboard on every output handshake and tracks the saturating count
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            check("beat_cnt", beat_cnt, exp_cnt);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL extra_beat got=0x%0h exp=none", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_op", out_op, e.op);
`ifdef LOGIC_UNIT_POPCNT_EN
                    check("out_popcnt", out_popcnt, e.pc);
`endif
                end
                if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    initial begin
        logic [7:0] held;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_op", out_op, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_in_ready", in_ready, 0);
`ifdef LOGIC_UNIT_POPCNT_EN
        check("rst_out_popcnt", out_popcnt, 0);
`endif
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        send(8'h18, 8'hE7, 3'd0, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_1cyc", out_valid, 0);
        @(negedge clk);
        check("latency_2cyc", out_valid, 1);
        drain();

        send(8'h18, 8'hE7, 3'd0, 8'h00);
        send(8'h18, 8'hE7, 3'd1, 8'hFF);
        send(8'h18, 8'hE7, 3'd2, 8'hFF);
        send(8'h18, 8'hE7, 3'd3, 8'hFF);
        drain();
        check("cnt_after_ops0_3", beat_cnt, 5);

        send(8'h18, 8'hE7, 3'd4, 8'h00);
        send(8'h18, 8'hE7, 3'd5, 8'h00);
        send(8'h18, 8'hE7, 3'd6, 8'h18);
        send(8'h18, 8'hE7, 3'd7, 8'h18);
        drain();
        check("cnt_after_ops4_7", beat_cnt, 9);

        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                for (int i = 0; i < 2; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_data_stable", out_data, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        send(8'h11, 8'h22, 3'd1, 8'h33);
        send(8'h44, 8'h0F, 3'd0, 8'h04);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_beat_cnt", beat_cnt, 0);
        check("midrst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("postrst_in_ready", in_ready, 1);
        send(8'hAA, 8'h0F, 3'd2, 8'hA5);
        drain();
        check("cnt_after_rst_beat", beat_cnt, 1);

        for (int i = 0; i < 20; i++) send_rand();
        drain();
        check("cnt_saturated", beat_cnt, 4'hF);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
